ctrl_seq_decoder: RTL and testbench

Clocked, parametrised successor to the combinational control decoder. It holds the mode-prefix state ("S") in a reset-able register instead of a latch. It adds instruction-valid gating, an optional one-shot mode, a HALT state with a sticky Ack, and illegal-opcode detection. It sits between instruction ROM and datapath; the fetch unit consumes BranchEn/Ack.

---
 rtl/ctrl_seq_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_ctrl_seq_decoder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq_decoder.sv
// Clocked control decoder: registered mode prefix, RUN/HALT sequencing with a sticky Ack,
// and one-cycle illegal-encoding flag. Datapath controls stay combinational for zero latency.
module ctrl_seq_decoder #(
  parameter int IW     = 9,
  parameter int MW     = 2,
  parameter int STICKY = 1,
  parameter int OPW    = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [IW-1:0]  Instruction,
  input  logic           InstrValid,
  output logic           MemWrite,
  output logic           BranchEn,
  output logic           ALUSrc,
  output logic           RegWrite,
  output logic           NextLFSR,
  output logic           RegOut1,
  output logic           RegOut2,
  output logic [1:0]     MemToReg,
  output logic [1:0]     RegDest,
  output logic [OPW-1:0] ALUOp,
  output logic [MW-1:0]  Mode,
  output logic           Ack,
  output logic           IllegalOp
);

  localparam logic [2:0] OP_MAX_DEC = 3'b100;
  localparam logic [2:0] OP_ILLEGAL = 3'b101;
  localparam logic [2:0] OP_SETMODE = 3'b110;
  localparam logic [2:0] OP_HALT    = 3'b111;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic       mem_write;
    logic       branch_en;
    logic       alu_src;
    logic       reg_write;
    logic       next_lfsr;
    logic       reg_out1;
    logic       reg_out2;
    logic [1:0] mem_to_reg;
    logic [1:0] reg_dest;
    logic [3:0] alu_op;
  } ctrl_t;

  state_t        state_q, state_d;
  logic [MW-1:0] mode_q, mode_d;
  logic          illegal_q, illegal_d;

  logic [2:0]    opcode;
  logic [1:0]    mode_lo;
  logic          mode_hi_set;
  logic          active;
  logic          illegal_enc;
  logic          decode_en;
  ctrl_t         ctrl_raw;
  ctrl_t         ctrl;
  logic          unused_instr;

  // Truth table for the defined opcodes; anything not listed decodes to all-zero.
  function automatic ctrl_t decode(input logic [2:0] op, input logic [1:0] md);
    ctrl_t c;
    c = '0;
    case (op)
      3'b000: begin
        case (md)
          2'b00: begin
            c.mem_to_reg = 2'b01;
            c.alu_src    = 1'b1;
            c.reg_write  = 1'b1;
            c.alu_op     = 4'd0;
          end
          2'b01: begin
            c.mem_write = 1'b1;
            c.alu_src   = 1'b1;
          end
          2'b10: begin
            c.reg_write = 1'b1;
            c.alu_op    = 4'd0;
          end
          default: begin
            c.reg_write = 1'b1;
            c.alu_op    = 4'd1;
          end
        endcase
      end
      3'b001: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        case (md)
          2'b00:   c.alu_op = 4'd2;
          2'b01:   c.alu_op = 4'd3;
          default: c.alu_op = 4'd4;
        endcase
        if (md == 2'b11) begin
          c.mem_to_reg = 2'b11;
          c.reg_dest   = 2'b01;
        end
      end
      3'b010: begin
        c.reg_write = (md != 2'b01);
        c.next_lfsr = (md == 2'b01);
        c.reg_out1  = (md == 2'b00);
        c.alu_op    = (md == 2'b11) ? 4'd6 : 4'd5;
      end
      3'b011: begin
        case (md)
          2'b00: begin
            c.reg_write = 1'b1;
            c.alu_op    = 4'd7;
          end
          2'b01: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 2'b10;
            c.reg_dest   = 2'b10;
            c.alu_op     = 4'd7;
          end
          2'b10: begin
            c.branch_en = 1'b1;
            c.alu_op    = 4'd8;
          end
          default: begin
            c.branch_en = 1'b1;
            c.alu_op    = 4'd9;
          end
        endcase
      end
      3'b100: begin
        case (md)
          2'b00: begin
            c.reg_write = 1'b1;
            c.reg_out2  = 1'b1;
            c.alu_op    = 4'd10;
          end
          2'b01: begin
            c.branch_en = 1'b1;
            c.alu_op    = 4'd11;
          end
          default: c.alu_op = 4'd11;
        endcase
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign opcode       = Instruction[IW-1:IW-3];
  assign mode_lo      = mode_q[1:0];
  assign mode_hi_set  = (mode_q >> 2) != '0;
  assign unused_instr = ^Instruction;

  // An instruction only counts when it is present, the sequencer runs and reset is idle.
  assign active      = InstrValid && (state_q == S_RUN) && !Reset;
  assign illegal_enc = (opcode == OP_ILLEGAL) || ((opcode <= OP_MAX_DEC) && mode_hi_set);
  assign decode_en   = active && !illegal_enc;

  always_comb begin
    ctrl_raw = decode(opcode, mode_lo);
    ctrl     = decode_en ? ctrl_raw : '0;
  end

  assign MemWrite  = ctrl.mem_write;
  assign BranchEn  = ctrl.branch_en;
  assign ALUSrc    = ctrl.alu_src;
  assign RegWrite  = ctrl.reg_write;
  assign NextLFSR  = ctrl.next_lfsr;
  assign RegOut1   = ctrl.reg_out1;
  assign RegOut2   = ctrl.reg_out2;
  assign MemToReg  = ctrl.mem_to_reg;
  assign RegDest   = ctrl.reg_dest;
  assign ALUOp     = OPW'(ctrl.alu_op);

  // SETMODE takes priority over the one-shot clear; illegal encodings still consume the mode.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    illegal_d = active && illegal_enc;
    if (active) begin
      if (opcode == OP_SETMODE) begin
        mode_d = Instruction[MW-1:0];
      end else if (STICKY == 0) begin
        mode_d = '0;
      end
      if (opcode == OP_HALT) begin
        state_d = S_HALT;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= S_RUN;
      mode_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      illegal_q <= illegal_d;
    end
  end

  assign Mode      = mode_q;
  assign Ack       = (state_q == S_HALT);
  assign IllegalOp = illegal_q;

endmodule

// File: tb/tb_ctrl_seq_decoder.sv
// Bench for ctrl_seq_decoder: two configurations (one-shot MW=3, sticky MW=2 with wide ALUOp)
// driven in parallel from a directed table, a hand sequence and random stimulus.
module tb_ctrl_seq_decoder;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [8:0] Instruction;
  logic       InstrValid;

  logic       a_mw, a_br, a_as, a_rw, a_nl, a_r1, a_r2, a_ack, a_ill;
  logic [1:0] a_mtr, a_rd;
  logic [3:0] a_op;
  logic [2:0] a_mode;

  logic       b_mw, b_br, b_as, b_rw, b_nl, b_r1, b_r2, b_ack, b_ill;
  logic [1:0] b_mtr, b_rd;
  logic [5:0] b_op;
  logic [1:0] b_mode;

  always #5 Clk = ~Clk;

  ctrl_seq_decoder #(.IW(9), .MW(3), .STICKY(0), .OPW(4)) dut_a (
    .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .InstrValid(InstrValid),
    .MemWrite(a_mw), .BranchEn(a_br), .ALUSrc(a_as), .RegWrite(a_rw), .NextLFSR(a_nl),
    .RegOut1(a_r1), .RegOut2(a_r2), .MemToReg(a_mtr), .RegDest(a_rd), .ALUOp(a_op),
    .Mode(a_mode), .Ack(a_ack), .IllegalOp(a_ill)
  );

  ctrl_seq_decoder #(.IW(9), .MW(2), .STICKY(1), .OPW(6)) dut_b (
    .Clk(Clk), .Reset(Reset), .Instruction(Instruction), .InstrValid(InstrValid),
    .MemWrite(b_mw), .BranchEn(b_br), .ALUSrc(b_as), .RegWrite(b_rw), .NextLFSR(b_nl),
    .RegOut1(b_r1), .RegOut2(b_r2), .MemToReg(b_mtr), .RegDest(b_rd), .ALUOp(b_op),
    .Mode(b_mode), .Ack(b_ack), .IllegalOp(b_ill)
  );

  logic [18:0] a_ctrl, b_ctrl;
  assign a_ctrl = {a_mw, a_br, a_as, a_rw, a_nl, a_r1, a_r2, a_mtr, a_rd, {4'b0, a_op}};
  assign b_ctrl = {b_mw, b_br, b_as, b_rw, b_nl, b_r1, b_r2, b_mtr, b_rd, {2'b0, b_op}};

  typedef struct {
    int mode;
    bit halted;
    bit ill;
  } mstate_t;

  typedef struct {
    logic [8:0]  ins;
    bit          v;
    bit          r;
    logic [18:0] ctrl;
    int          mode;
    bit          ack;
    bit          ill;
  } vec_t;

  logic [18:0] dec_tab [0:19];
  mstate_t     ma, mb;
  vec_t        tbl[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [18:0] ctl(bit mw, bit br, bit as_, bit rw, bit nl, bit r1, bit r2,
                                      logic [1:0] mtr, logic [1:0] rd, int op);
    logic [7:0] op8;
    op8 = 8'(op);
    return {mw, br, as_, rw, nl, r1, r2, mtr, rd, op8};
  endfunction

  // Reference: controls are a table lookup on {opcode, mode}, masked by the gating rules.
  function automatic logic [18:0] model_ctrl(mstate_t s, logic [8:0] ins, bit v, bit r);
    int op;
    op = int'(ins[8:6]);
    if (r || !v || s.halted) return '0;
    if (op >= 5) return '0;
    if (s.mode >= 4) return '0;
    return dec_tab[op * 4 + s.mode];
  endfunction

  function automatic mstate_t model_next(mstate_t s, int mw, bit sticky,
                                         logic [8:0] ins, bit v, bit r);
    mstate_t n;
    int op;
    op = int'(ins[8:6]);
    if (r) begin
      n.mode = 0; n.halted = 1'b0; n.ill = 1'b0;
      return n;
    end
    n = s;
    n.ill = v && !s.halted && (op == 5 || (op <= 4 && s.mode >= 4));
    if (v && !s.halted) begin
      if (op == 6) n.mode = int'(ins) % (1 << mw);
      else if (!sticky) n.mode = 0;
      if (op == 7) n.halted = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [31:0] stat(int mode, bit ack, bit ill);
    return 32'((mode << 2) | (int'(ack) << 1) | int'(ill));
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (vector %0d): got %0h, expected %0h", name, n_vec, act, exp);
    end
  endtask

  task automatic apply(logic [8:0] ins, bit v, bit r);
    @(negedge Clk);
    Instruction = ins;
    InstrValid  = v;
    Reset       = r;
    #1;
    chk("a_ctrl", 32'(a_ctrl), 32'(model_ctrl(ma, ins, v, r)));
    chk("a_stat", stat(int'(a_mode), a_ack, a_ill), stat(ma.mode, ma.halted, ma.ill));
    chk("b_ctrl", 32'(b_ctrl), 32'(model_ctrl(mb, ins, v, r)));
    chk("b_stat", stat(int'(b_mode), b_ack, b_ill), stat(mb.mode, mb.halted, mb.ill));
    ma = model_next(ma, 3, 1'b0, ins, v, r);
    mb = model_next(mb, 2, 1'b1, ins, v, r);
  endtask

  task automatic add(logic [8:0] ins, bit v, bit r, logic [18:0] c, int mode, bit ack, bit ill);
    vec_t e;
    e.ins = ins; e.v = v; e.r = r; e.ctrl = c; e.mode = mode; e.ack = ack; e.ill = ill;
    tbl.push_back(e);
  endtask

  initial begin
    logic [18:0] z, ld0, op2, op5r1;
    dec_tab[0]  = ctl(0,0,1,1,0,0,0,2'b01,2'b00,0);
    dec_tab[1]  = ctl(1,0,1,0,0,0,0,2'b00,2'b00,0);
    dec_tab[2]  = ctl(0,0,0,1,0,0,0,2'b00,2'b00,0);
    dec_tab[3]  = ctl(0,0,0,1,0,0,0,2'b00,2'b00,1);
    dec_tab[4]  = ctl(0,0,1,1,0,0,0,2'b00,2'b00,2);
    dec_tab[5]  = ctl(0,0,1,1,0,0,0,2'b00,2'b00,3);
    dec_tab[6]  = ctl(0,0,1,1,0,0,0,2'b00,2'b00,4);
    dec_tab[7]  = ctl(0,0,1,1,0,0,0,2'b11,2'b01,4);
    dec_tab[8]  = ctl(0,0,0,1,0,1,0,2'b00,2'b00,5);
    dec_tab[9]  = ctl(0,0,0,0,1,0,0,2'b00,2'b00,5);
    dec_tab[10] = ctl(0,0,0,1,0,0,0,2'b00,2'b00,5);
    dec_tab[11] = ctl(0,0,0,1,0,0,0,2'b00,2'b00,6);
    dec_tab[12] = ctl(0,0,0,1,0,0,0,2'b00,2'b00,7);
    dec_tab[13] = ctl(0,0,0,1,0,0,0,2'b10,2'b10,7);
    dec_tab[14] = ctl(0,1,0,0,0,0,0,2'b00,2'b00,8);
    dec_tab[15] = ctl(0,1,0,0,0,0,0,2'b00,2'b00,9);
    dec_tab[16] = ctl(0,0,0,1,0,0,1,2'b00,2'b00,10);
    dec_tab[17] = ctl(0,1,0,0,0,0,0,2'b00,2'b00,11);
    dec_tab[18] = ctl(0,0,0,0,0,0,0,2'b00,2'b00,11);
    dec_tab[19] = ctl(0,0,0,0,0,0,0,2'b00,2'b00,11);

    z     = '0;
    ld0   = ctl(0,0,1,1,0,0,0,2'b01,2'b00,0);
    op2   = ctl(0,0,1,1,0,0,0,2'b00,2'b00,2);
    op5r1 = ctl(0,0,0,1,0,1,0,2'b00,2'b00,5);

    // Directed sequence; expectations are for the one-shot, MW=3 instance.
    add(9'b000_000_000, 1, 1, z,   0, 0, 0);
    add(9'b000_000_000, 1, 0, ld0, 0, 0, 0);
    add(9'b110_000_001, 1, 0, z,   0, 0, 0);
    add(9'b000_000_000, 1, 0, ctl(1,0,1,0,0,0,0,2'b00,2'b00,0), 1, 0, 0);
    add(9'b000_000_000, 1, 0, ld0, 0, 0, 0);
    add(9'b110_000_011, 1, 0, z,   0, 0, 0);
    add(9'b011_000_000, 1, 0, ctl(0,1,0,0,0,0,0,2'b00,2'b00,9), 3, 0, 0);
    add(9'b011_000_000, 1, 0, ctl(0,0,0,1,0,0,0,2'b00,2'b00,7), 0, 0, 0);
    add(9'b110_000_010, 0, 0, z,   0, 0, 0);
    add(9'b000_000_000, 1, 0, ld0, 0, 0, 0);
    add(9'b101_000_000, 1, 0, z,   0, 0, 0);
    add(9'b000_000_000, 1, 0, ld0, 0, 0, 1);
    add(9'b110_000_100, 1, 0, z,   0, 0, 0);
    add(9'b001_000_000, 1, 0, z,   4, 0, 0);
    add(9'b001_000_000, 1, 0, op2, 0, 0, 1);
    add(9'b010_000_000, 1, 0, op5r1, 0, 0, 0);
    add(9'b111_000_000, 1, 0, z,   0, 0, 0);
    add(9'b001_000_000, 1, 0, z,   0, 1, 0);
    add(9'b110_000_001, 1, 0, z,   0, 1, 0);
    add(9'b110_000_001, 1, 1, z,   0, 1, 0);
    add(9'b001_000_000, 1, 0, op2, 0, 0, 0);
    add(9'b111_000_000, 1, 1, z,   0, 0, 0);
    add(9'b000_000_000, 1, 0, ld0, 0, 0, 0);

    ma.mode = 0; ma.halted = 1'b0; ma.ill = 1'b0;
    mb = ma;
    Reset = 1'b1; InstrValid = 1'b0; Instruction = '0;
    repeat (2) @(negedge Clk);

    foreach (tbl[i]) begin
      apply(tbl[i].ins, tbl[i].v, tbl[i].r);
      chk("tbl_ctrl", 32'(a_ctrl), 32'(tbl[i].ctrl));
      chk("tbl_stat", stat(int'(a_mode), a_ack, a_ill), stat(tbl[i].mode, tbl[i].ack, tbl[i].ill));
    end

    // Sticky instance keeps mode 10 across several instructions.
    apply(9'b110_000_010, 1, 0);
    repeat (3) begin
      apply(9'b010_000_000, 1, 0);
      chk("sticky_ctrl", 32'(b_ctrl), 32'(ctl(0,0,0,1,0,0,0,2'b00,2'b00,5)));
      chk("sticky_mode", 32'(b_mode), 32'd2);
    end

    for (int k = 0; k < 3000; k++) begin
      logic [8:0] ins;
      bit v, r;
      ins = 9'($urandom);
      if ($urandom_range(0, 99) < 3) ins[8:6] = 3'b111;
      else ins[8:6] = 3'($urandom_range(0, 6));
      v = ($urandom_range(0, 9) < 8);
      r = ($urandom_range(0, 99) < (ma.halted || mb.halted ? 15 : 2));
      apply(ins, v, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
